// File: rtl/fixedpoint_pkg.sv
// Shared constants and types for the fixed-point datapath.
// Number format: 16-bit two's complement, 7 fraction bits.
package fixedpoint_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 7;
    localparam int MAGW  = WIDTH + 1;
    localparam int ACCW  = 2 * WIDTH + 2;
    localparam int TW    = ACCW - FRAC;
    localparam int CNTW  = $clog2(WIDTH + 1);

    // Largest positive and negative result magnitudes after the FRAC shift.
    localparam logic [TW-1:0] POS_MAX = TW'((1 << (WIDTH - 1)) - 1);
    localparam logic [TW-1:0] NEG_MIN = TW'(1 << (WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fixedpoint_magnitude.sv
// Two's complement value to sign plus magnitude.
// One extra magnitude bit so the most negative value does not wrap.
module fixedpoint_magnitude #(
    parameter int W = 16
) (
    input  logic [W-1:0] val_i,
    output logic         sign_o,
    output logic [W:0]   mag_o
);

    logic [W:0] ext;

    // Sign-extend, then negate negative values.
    always_comb begin
        sign_o = val_i[W-1];
        ext    = {val_i[W-1], val_i};
        mag_o  = sign_o ? (~ext + 1'b1) : ext;
    end

endmodule

// File: rtl/fixedpoint_multiplication.sv
// Sequential signed fixed-point multiplier.
// Radix-2 shift-add on magnitudes, sign fix-up and range check.
module fixedpoint_multiplication
    import fixedpoint_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product_out,
    output logic             overflow,
    output logic             error,
    output logic             finished
);

    state_t state_q, state_d;

    logic [CNTW-1:0]  cnt_q;
    logic [MAGW-1:0]  mag_a_q, mag_b_q;
    logic [ACCW-1:0]  acc_q;
    logic             sign_q;
    logic [WIDTH-1:0] prod_q;
    logic             ovf_q;
    logic             fin_q;

    logic             sign_a, sign_b;
    logic [MAGW-1:0]  mag_a, mag_b;
    logic             start;
    logic [TW-1:0]    t_w;
    logic [WIDTH-1:0] t_lo;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;

    fixedpoint_magnitude #(.W(WIDTH)) u_mag_a (
        .val_i  (multiplicand),
        .sign_o (sign_a),
        .mag_o  (mag_a)
    );

    fixedpoint_magnitude #(.W(WIDTH)) u_mag_b (
        .val_i  (multiplier),
        .sign_o (sign_b),
        .mag_o  (mag_b)
    );

    assign start = enable && (state_q == IDLE || state_q == DONE);

    // Next state: enable only accepted when idle or done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (enable) state_d = BUSY;
            BUSY:       if (cnt_q == CNTW'(WIDTH)) state_d = FINAL;
            FINAL:      state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Iteration counter, one step per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cnt_q <= '0;
        else if (start)          cnt_q <= '0;
        else if (state_q == BUSY) cnt_q <= cnt_q + 1'b1;
    end

    // Operand latch and shift-add accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a_q <= '0;
            mag_b_q <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
        end else if (start) begin
            mag_a_q <= mag_a;
            mag_b_q <= mag_b;
            sign_q  <= sign_a ^ sign_b;
            acc_q   <= '0;
        end else if (state_q == BUSY) begin
            if (mag_b_q[0])
                acc_q <= acc_q + (ACCW'(mag_a_q) << cnt_q);
            mag_b_q <= mag_b_q >> 1;
        end
    end

    // Truncate toward zero, range check, apply sign.
    always_comb begin
        t_w   = acc_q[ACCW-1:FRAC];
        t_lo  = t_w[WIDTH-1:0];
        ovf_c = sign_q ? (t_w > NEG_MIN) : (t_w > POS_MAX);
        res_c = sign_q ? (~t_lo + 1'b1) : t_lo;
    end

    // Result registers, held until the next accepted enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            ovf_q  <= 1'b0;
            fin_q  <= 1'b0;
        end else if (start) begin
            fin_q  <= 1'b0;
        end else if (state_q == FINAL) begin
            prod_q <= res_c;
            ovf_q  <= ovf_c;
            fin_q  <= 1'b1;
        end
    end

    assign product_out = prod_q;
    assign overflow    = ovf_q;
    assign error       = ovf_q;
    assign finished    = fin_q;

endmodule

// File: tb/tb_fixedpoint_multiplication.sv
// Scoreboard bench for fixedpoint_multiplication.
// Expected results come from a signed integer reference model.
module tb_fixedpoint_multiplication;

    typedef struct packed {
        logic [15:0] prod;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [15:0] product_out;
    logic        overflow;
    logic        error;
    logic        finished;

    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    fixedpoint_multiplication dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product_out  (product_out),
        .overflow     (overflow),
        .error        (error),
        .finished     (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Q8.7 multiply: exact signed product divided by 128 (truncates to zero).
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint p;
        longint t;
        p      = longint'($signed(a)) * longint'($signed(b));
        t      = p / 128;
        e.ovf  = (t > 32767) || (t < -32768);
        e.prod = t[15:0];
        return e;
    endfunction

    task automatic start(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        enable       = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        sb_q.push_back(model(a, b));
    endtask

    // Wait for finished; rp > 0 re-pulses enable with junk operands.
    task automatic wait_result(input int rp);
        int   lat;
        exp_t e;
        lat = 31;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (n == rp) begin
                enable       = 1'b1;
                multiplicand = 16'($urandom);
                multiplier   = 16'($urandom);
            end else begin
                enable = 1'b0;
            end
            if (finished) begin
                lat = n;
                break;
            end
        end
        enable = 1'b0;
        chk("latency", 32'(lat), 32'd18);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("product", 32'(product_out), 32'(e.prod));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("error", 32'(error), 32'(e.ovf));
            chk("finished", 32'(finished), 32'd1);
            multiplicand = 16'($urandom);
            multiplier   = 16'($urandom);
            repeat (3) @(posedge clk);
            #1;
            chk("hold", 32'(product_out), 32'(e.prod));
            chk("hold_fin", 32'(finished), 32'd1);
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b);
        start(a, b);
        wait_result(0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        enable       = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prod", 32'(product_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_fin", 32'(finished), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(16'h01C0, 16'hFF00);
        chk("c1_const", 32'(product_out), 32'h0000_FC80);
        run(16'hFC80, 16'hFFC0);
        run(16'h0040, 16'h0040);
        run(16'h4000, 16'h0100);
        chk("c3_wrap", 32'(product_out), 32'h0000_8000);
        chk("c3_ovf", 32'(overflow), 32'd1);
        run(16'hC000, 16'h0100);
        chk("c3_min_ovf", 32'(overflow), 32'd0);
        run(16'h0001, 16'h0001);
        run(16'hFFFF, 16'h0001);
        chk("c4_negzero", 32'(product_out), 32'd0);
        run(16'h8000, 16'h8000);
        run(16'h0000, 16'h8000);
        run(16'h8000, 16'h0080);
        run(16'h7FFF, 16'h0080);

        start(16'h0633, 16'h02A0);
        wait_result(5);

        start(16'h0633, 16'h0123);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_prod", 32'(product_out), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_err", 32'(error), 32'd0);
        chk("mid_rst_fin", 32'(finished), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("rst_idle_fin", 32'(finished), 32'd0);
        run(16'h2580, 16'h0040);
        chk("c6_const", 32'(product_out), 32'h0000_12C0);

        for (int i = 0; i < 10; i++)
            run(16'($urandom), 16'($urandom));

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
